// File: rtl/mxdp_sched_pkg.sv
// mxdp_sched_pkg: shared widths and operand/response types for the MXINT8 dot-product scheduler.
package mxdp_sched_pkg;
  localparam int SCALE_WIDTH = 8;
  localparam int BLOCK_SIZE = 32;
  localparam int MXINT8_ELEMENT_WIDTH = 8;
  localparam int FLOAT32_WIDTH = 32;
  // Wide enough for the largest supported requester count (8).
  localparam int MAX_ID_W = 3;
  typedef logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] mx_block_t;
  typedef struct packed {
    logic [SCALE_WIDTH-1:0] scale_a;
    logic [SCALE_WIDTH-1:0] scale_b;
    mx_block_t elements_a;
    mx_block_t elements_b;
  } mx_operand_t;
  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [FLOAT32_WIDTH-1:0] float32;
    logic overflow;
    logic underflow;
    logic unused;
    logic NaN;
  } mx_rsp_t;
endpackage

// File: rtl/mxdp_rsp_fifo.sv
// mxdp_rsp_fifo: synchronous response FIFO; the head is read straight from storage and forced to zero when empty.
module mxdp_rsp_fifo
  import mxdp_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  mx_rsp_t       i_data,
  input  logic          i_pop,
  output logic          o_valid,
  output mx_rsp_t       o_head,
  output logic [CW-1:0] o_count
);
  logic [PW-1:0] r_wr, r_rd;
  logic [CW-1:0] r_count;
  logic w_pop;
  mx_rsp_t r_mem [DEPTH];
  assign o_valid = r_count != '0;
  assign w_pop = i_pop && o_valid;
  assign o_head = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      assert (!(i_push && !w_pop && r_count == CW'(DEPTH)));
      if (i_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/mxint8_dot_product_sched.sv
// mxint8_dot_product_sched: round-robin, credit-limited scheduler sharing one MXINT8 dot-product datapath.
// Per-requester issue and exception statistics are added when MXDP_SCHED_STATS_EN is defined.
module mxint8_dot_product_sched
  import mxdp_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DP_LATENCY = 3,
  parameter int RSP_DEPTH  = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [NUM_REQ-1:0]                                      req_valid,
  output logic [NUM_REQ-1:0]                                      req_ready,
  input  logic [NUM_REQ-1:0][SCALE_WIDTH-1:0]                     req_scale_a,
  input  logic [NUM_REQ-1:0][SCALE_WIDTH-1:0]                     req_scale_b,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] req_elements_a,
  input  logic [NUM_REQ-1:0][BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0] req_elements_b,
  output logic                                                    dp_valid,
  output logic [SCALE_WIDTH-1:0]                                  dp_scale_a,
  output logic [SCALE_WIDTH-1:0]                                  dp_scale_b,
  output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]         dp_elements_a,
  output logic [BLOCK_SIZE-1:0][MXINT8_ELEMENT_WIDTH-1:0]         dp_elements_b,
  input  logic [FLOAT32_WIDTH-1:0]                                dp_float32,
  input  logic                                                    dp_overflow,
  input  logic                                                    dp_underflow,
  input  logic                                                    dp_unused,
  input  logic                                                    dp_NaN,
  output logic                                                    rsp_valid,
  input  logic                                                    rsp_ready,
  output logic [ID_W-1:0]                                         rsp_id,
  output logic [FLOAT32_WIDTH-1:0]                                rsp_float32,
  output logic                                                    rsp_overflow,
  output logic                                                    rsp_underflow,
  output logic                                                    rsp_unused,
  output logic                                                    rsp_NaN
`ifdef MXDP_SCHED_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]                                stat_issued,
  output logic [15:0]                                             stat_exc
`endif
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [ID_W-1:0] r_rr, r_dp_id, w_gnt;
  logic [2*NUM_REQ-1:0] w_rot;
  logic w_found, w_issue, w_pop, w_rsp_valid, r_dp_valid;
  logic [CW-1:0] r_credits, w_count;
  logic [DP_LATENCY-1:0] r_pv;
  logic [DP_LATENCY-1:0][ID_W-1:0] r_pid;
  mx_operand_t r_op;
  mx_rsp_t w_push_data, w_head;
  // Rotating by rr_ptr turns "first valid at or after rr_ptr" into a plain lowest-set-bit search.
  assign w_rot = {req_valid, req_valid} >> r_rr;
  always_comb begin
    w_found = 1'b0;
    w_gnt = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_gnt = ID_W'((int'(r_rr) + i) % NUM_REQ);
      end
  end
  // rst_n gating keeps req_ready low for the whole reset window, credits notwithstanding.
  assign w_issue = rst_n && w_found && r_credits != '0;
  assign req_ready = w_issue ? NUM_REQ'(1) << w_gnt : '0;
  assign w_pop = w_rsp_valid && rsp_ready;
  assign dp_valid = r_dp_valid;
  assign dp_scale_a = r_op.scale_a;
  assign dp_scale_b = r_op.scale_b;
  assign dp_elements_a = r_op.elements_a;
  assign dp_elements_b = r_op.elements_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_rr <= '0;
      r_dp_valid <= 1'b0;
      r_dp_id <= '0;
      r_op <= '0;
      r_pv <= '0;
      r_pid <= '0;
      r_credits <= CW'(RSP_DEPTH);
    end else begin
      assert (int'(r_credits) + int'(w_count) <= RSP_DEPTH && w_head.id < MAX_ID_W'(NUM_REQ));
      r_dp_valid <= w_issue;
      r_pv <= DP_LATENCY'({r_pv, r_dp_valid});
      r_pid <= (DP_LATENCY * ID_W)'({r_pid, r_dp_id});
      r_credits <= r_credits - CW'(w_issue) + CW'(w_pop);
      if (w_issue) begin
        r_rr <= (w_gnt == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt + 1'b1;
        r_dp_id <= w_gnt;
        r_op <= '{scale_a: req_scale_a[w_gnt], scale_b: req_scale_b[w_gnt],
                  elements_a: req_elements_a[w_gnt], elements_b: req_elements_b[w_gnt]};
      end
    end
  assign w_push_data = '{id: MAX_ID_W'(r_pid[DP_LATENCY-1]), float32: dp_float32, overflow: dp_overflow,
                         underflow: dp_underflow, unused: dp_unused, NaN: dp_NaN};
  mxdp_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_pv[DP_LATENCY-1]),
    .i_data (w_push_data),
    .i_pop  (w_pop),
    .o_valid(w_rsp_valid),
    .o_head (w_head),
    .o_count(w_count)
  );
  assign rsp_valid = w_rsp_valid;
  assign rsp_id = w_head.id[ID_W-1:0];
  assign rsp_float32 = w_head.float32;
  assign rsp_overflow = w_head.overflow;
  assign rsp_underflow = w_head.underflow;
  assign rsp_unused = w_head.unused;
  assign rsp_NaN = w_head.NaN;
`ifdef MXDP_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_issued <= '0;
      stat_exc <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (w_issue && w_gnt == ID_W'(i) && stat_issued[i] != 16'hFFFF) stat_issued[i] <= stat_issued[i] + 1'b1;
      if (w_pop && (w_head.NaN || w_head.overflow) && stat_exc != 16'hFFFF) stat_exc <= stat_exc + 1'b1;
    end
`endif
endmodule
